fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Upstream producer and consumer for icache_memctl's instruction port.
- Owns the PC and issues one instruction request at a time via instruction_addr/need_instruction.
- Captures each returned word into a small instruction queue (IQ) that the decoder drains with a valid/pop handshake.
- Statically predicts JAL as taken, everything else as PC+4; empties and redirects on pipeline flush.

Parameters:
- IQ_DEPTH_LOG, 3, log2 of IQ entries (default 8 entries).
- RESET_PC, 32'h0, PC value loaded on reset.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global enable; when low, all state holds
- flush  in  1  pipeline flush from commit; same signal that drives icache_memctl.flush
- flush_pc  in  32  redirect target, valid when flush=1
- instruction_ready  in  2  from icache_memctl: [1] = word valid this cycle, [0] = controller instruction side idle
- instruction_data  in  32  returned instruction word
- instruction_addr_out  in  32  address of the returned word
- instruction_addr  out  32  request address to icache_memctl
- need_instruction  out  1  one-cycle request pulse
- iq_valid  out  1  IQ non-empty
- iq_pc  out  32  head entry PC
- iq_inst  out  32  head entry instruction
- iq_pred_taken  out  1  head entry was predicted as a taken JAL
- iq_pop  in  1  decoder consumes head when iq_valid && iq_pop

Behaviour:
- Reset (clk edge with rst=1):
  - pc=RESET_PC, state=IDLE, IQ count/head/tail=0.
  - need_instruction=0, instruction_addr=0.
  - iq_valid=0; iq_pc, iq_inst, iq_pred_taken read as 0.
  - Reset mid-request abandons the request; icache_memctl is reset by the same rst.
- rdy=0: no register changes; need_instruction keeps its value (the controller is frozen too).
- FSM states: IDLE and WAIT.
  - IDLE → WAIT when !flush && instruction_ready[0] && (count + 1 <= 2^IQ_DEPTH_LOG, counting a pop in the same cycle as freeing a slot). In that cycle register need_instruction=1 and instruction_addr=pc.
  - WAIT: need_instruction=0; instruction_addr holds pc.
  - WAIT → IDLE on instruction_ready[1] && !flush: push {instruction_addr_out, instruction_data, pred} into the IQ and update pc.
  - Only one request is ever outstanding, so the controller's has_next_instruction path is never exercised.
- Next-PC rule on receive:
  - If inst[6:0]==7'b1101111 (JAL): J-imm = sign-extended {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}; pc = addr + J-imm (32-bit wrap); pred=1.
  - Otherwise pc = addr + 4 (wraps at 2^32); pred=0.
- Minimum request-to-request spacing is response latency + 1 cycle. The next request may issue the cycle after the push, since instruction_ready[0] is already 1 by then.
- IQ:
  - Circular buffer; pointers wrap modulo 2^IQ_DEPTH_LOG.
  - Push and pop in the same cycle are allowed at any count, including full, because credit is reserved at request time. Count is unchanged in that case.
  - Pop when empty is ignored.
  - Head outputs are driven combinationally from the head entry.
- flush (highest priority, overrides every other action that cycle):
  - IQ emptied (head=tail=count=0), so iq_valid=0 the next cycle.
  - pc=flush_pc, state=IDLE, need_instruction=0.
  - Any instruction_ready[1] in the flush cycle is discarded.
  - A pending WAIT is abandoned; the controller clears its own state on the same flush.
  - A new request may issue no earlier than the cycle after flush.
- Misaligned flush_pc is passed through unchanged; no exception is generated here.

Decomposition:
- Shared package holds:
  - OPC_JAL = 7'b1101111
  - XLEN = 32
  - the J-immediate extraction function (reused by the decoder)
  - the IQ entry layout {pred[0], inst[31:0], pc[31:0]}, 65 bits
- One sub-module: fetch_queue, the parameterised circular FIFO with push, pop, clear, count, full and head outputs.
- The FSM, PC and predictor stay in fetch_unit.

Test Plan:
1. Reset with RESET_PC=0; controller model returns words 3 cycles after each request; decoder pops every cycle → requests at 0,4,8,…; IQ receives pc=0,4,8 in order; need_instruction is never high on two consecutive cycles.
2. Word 32'h0080006F (jal x0,+8) at pc=0x10 → next instruction_addr=0x18; head entry has iq_pred_taken=1. Word 32'hFFDFF06F (jal -4) at pc=0x18 → next request 0x14.
3. No pops with IQ_DEPTH_LOG=3 → exactly 8 pushes, then need_instruction stays 0. One pop → exactly one further request issues.
4. Flush with flush_pc=0x100 in the same cycle as instruction_ready[1] → that word is dropped, iq_valid=0 the next cycle, and the next request uses addr 0x100.
5. IQ full with a response arriving and iq_pop=1 in the same cycle → count stays 8, head advances, new entry appears at the tail with no loss.
6. rdy=0 for 5 cycles mid-WAIT → all outputs frozen; the response after rdy returns is pushed normally; rst asserted mid-WAIT → all outputs return to reset values next cycle.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared fetch/decode definitions: ISA constants, IQ entry layout, J-immediate extraction.
package fetch_unit_pkg;

  localparam int unsigned XLEN    = 32;
  localparam logic [6:0]  OPC_JAL = 7'b1101111;

  typedef enum logic [0:0] {StIdle, StWait} fetch_state_e;

  typedef struct packed {
    logic            pred;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } iq_entry_t;

  function automatic logic [XLEN-1:0] j_imm(input logic [XLEN-1:0] inst);
    return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus: instruction port towards icache_memctl plus the decoder-facing IQ head.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic [1:0]      instruction_ready;
  logic [XLEN-1:0] instruction_data;
  logic [XLEN-1:0] instruction_addr_out;
  logic [XLEN-1:0] instruction_addr;
  logic            need_instruction;
  logic            iq_valid;
  logic [XLEN-1:0] iq_pc;
  logic [XLEN-1:0] iq_inst;
  logic            iq_pred_taken;
  logic            iq_pop;

  modport master (
    input  instruction_ready, instruction_data, instruction_addr_out, iq_pop,
    output instruction_addr, need_instruction, iq_valid, iq_pc, iq_inst, iq_pred_taken
  );

  modport slave (
    output instruction_ready, instruction_data, instruction_addr_out, iq_pop,
    input  instruction_addr, need_instruction, iq_valid, iq_pc, iq_inst, iq_pred_taken
  );

endinterface

// File: rtl/fetch_queue.sv
// Circular instruction queue with push, pop and clear; head entry reads as zero when empty.
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int unsigned DepthLog = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  iq_entry_t         push_entry_i,
  output iq_entry_t         head_o,
  output logic [DepthLog:0] count_o,
  output logic              full_o
);

  localparam int unsigned         Depth  = 2 ** DepthLog;
  localparam logic [DepthLog-1:0] PtrOne = DepthLog'(1);
  localparam logic [DepthLog:0]   CntOne = (DepthLog + 1)'(1);

  iq_entry_t             mem_q [Depth];
  iq_entry_t             mem_d [Depth];
  logic [DepthLog-1:0]   head_q, head_d, tail_q, tail_d;
  logic [DepthLog:0]     count_q, count_d;
  logic                  pop_ok, push_ok;

  assign pop_ok  = pop_i && (count_q != '0);
  // A slot freed by a same-cycle pop may be refilled, so push at full is legal then.
  assign push_ok = push_i && (!count_q[DepthLog] || pop_ok);

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) begin
        mem_d[tail_q] = push_entry_i;
        tail_d        = tail_q + PtrOne;
      end
      if (pop_ok) begin
        head_d = head_q + PtrOne;
      end
      unique case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CntOne;
        2'b01:   count_d = count_q - CntOne;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign head_o  = (count_q == '0) ? '0 : mem_q[head_q];
  assign count_o = count_q;
  assign full_o  = count_q[DepthLog];

endmodule

// File: rtl/fetch_unit.sv
// Fetch unit: owns the PC, issues one request at a time, predicts JAL taken, fills the IQ.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned     IQ_DEPTH_LOG = 3,
  parameter logic [XLEN-1:0] RESET_PC     = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  input  logic            flush,
  input  logic [XLEN-1:0] flush_pc,
  fetch_unit_if.master    bus
);

  fetch_state_e          state_q, state_d;
  logic [XLEN-1:0]       pc_q, pc_d, addr_q, addr_d;
  logic                  need_q, need_d;
  logic [IQ_DEPTH_LOG:0] iq_count;
  logic                  iq_full, pop_fire, has_credit, issue, recv, is_jal;
  logic [XLEN-1:0]       next_pc;
  iq_entry_t             push_entry, head;

  // Credit is reserved at request time; a pop in the same cycle frees a slot.
  assign pop_fire   = bus.iq_valid && bus.iq_pop;
  assign has_credit = !iq_full || pop_fire;
  assign issue = (state_q == StIdle) && !flush && bus.instruction_ready[0] && has_credit;
  assign recv  = (state_q == StWait) && !flush && bus.instruction_ready[1];

  assign is_jal  = (bus.instruction_data[6:0] == OPC_JAL);
  assign next_pc = is_jal ? bus.instruction_addr_out + j_imm(bus.instruction_data)
                          : bus.instruction_addr_out + XLEN'(4);

  assign push_entry = '{pred: is_jal, inst: bus.instruction_data, pc: bus.instruction_addr_out};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else if (rdy) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (issue) state_d = StWait;
      StWait:  if (flush || recv) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pc_d   = pc_q;
    addr_d = addr_q;
    need_d = 1'b0;
    if (flush) begin
      pc_d = flush_pc;
    end else if (issue) begin
      need_d = 1'b1;
      addr_d = pc_q;
    end else if (recv) begin
      pc_d = next_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      addr_q <= '0;
      need_q <= 1'b0;
    end else if (rdy) begin
      pc_q   <= pc_d;
      addr_q <= addr_d;
      need_q <= need_d;
    end
  end

  fetch_queue #(
    .DepthLog (IQ_DEPTH_LOG)
  ) u_queue (
    .clk_i        (clk),
    .rst_i        (rst),
    .clear_i      (rdy && flush),
    .push_i       (rdy && recv),
    .pop_i        (rdy && bus.iq_pop),
    .push_entry_i (push_entry),
    .head_o       (head),
    .count_o      (iq_count),
    .full_o       (iq_full)
  );

  assign bus.instruction_addr = addr_q;
  assign bus.need_instruction = need_q;
  assign bus.iq_valid         = (iq_count != '0);
  assign bus.iq_pc            = head.pc;
  assign bus.iq_inst          = head.inst;
  assign bus.iq_pred_taken    = head.pred;

endmodule
